// File: rtl/intf_rr_arbiter.sv
// Round-robin arbiter granting one shared interface slot to one of N_REQ requesters.
// Optional INTF_RR_ARBITER_GAP_EN inserts a one-cycle dead GAP state between ownerships.
module intf_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     busy,
  output logic                     preempt
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
`ifdef INTF_RR_ARBITER_GAP_EN
    S_GAP,
`endif
    S_OWN
  } state_t;

  state_t            state, state_n;
  logic [N_REQ-1:0]  gnt_n;
  logic [IW-1:0]     idx_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              pre_n;
  logic              rel_a, rel_b, rel_c, rel_any;
  logic [N_REQ-1:0]  cand;
  logic              found;
  logic [IW-1:0]     pick;
  logic [N_REQ-1:0]  pick_oh;
`ifdef INTF_RR_ARBITER_GAP_EN
  logic [IW-1:0]     pend, pend_n;
  logic [N_REQ-1:0]  pend_oh;
`endif

  always_comb begin
    rel_a   = done[gnt_idx];
    rel_b   = !req[gnt_idx];
    rel_c   = (HOLD_MAX > 0) && (cnt == CW'(HOLD_MAX));
    rel_any = (state == S_OWN) && (rel_a || rel_b || rel_c);
    // A timeout alone leaves the owner eligible so a sole requester regains the grant.
    cand = req;
    if (state == S_OWN && (rel_a || rel_b)) cand[gnt_idx] = 1'b0;
    found = 1'b0;
    pick  = gnt_idx;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned pos;
      pos = (int'(gnt_idx) + k) % N_REQ;
      if (!found && cand[pos]) begin
        found = 1'b1;
        pick  = IW'(pos);
      end
    end
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    idx_n   = gnt_idx;
    cnt_n   = cnt;
    pre_n   = 1'b0;
`ifdef INTF_RR_ARBITER_GAP_EN
    pend_n        = pend;
    pend_oh       = '0;
    pend_oh[pend] = 1'b1;
`endif
    case (state)
      S_IDLE: begin
        if (found) begin
          state_n = S_OWN;
          gnt_n   = pick_oh;
          idx_n   = pick;
          cnt_n   = CW'(1);
        end
      end
      S_OWN: begin
        if (rel_any) begin
          pre_n = rel_c && !rel_a && !rel_b;
          if (!found) begin
            state_n = S_IDLE;
            gnt_n   = '0;
          end else begin
`ifdef INTF_RR_ARBITER_GAP_EN
            state_n = S_GAP;
            gnt_n   = '0;
            pend_n  = pick;
`else
            gnt_n   = pick_oh;
            idx_n   = pick;
            cnt_n   = CW'(1);
`endif
          end
        end else if (HOLD_MAX > 0) begin
          cnt_n = cnt + CW'(1);
        end
      end
`ifdef INTF_RR_ARBITER_GAP_EN
      S_GAP: begin
        state_n = S_OWN;
        gnt_n   = pend_oh;
        idx_n   = pend;
        cnt_n   = CW'(1);
      end
`endif
      default: begin
        state_n = S_IDLE;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      gnt     <= '0;
      gnt_idx <= LAST_IDX;
      busy    <= 1'b0;
      preempt <= 1'b0;
      cnt     <= '0;
`ifdef INTF_RR_ARBITER_GAP_EN
      pend    <= LAST_IDX;
`endif
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      gnt_idx <= idx_n;
      busy    <= |gnt_n;
      preempt <= pre_n;
      cnt     <= cnt_n;
`ifdef INTF_RR_ARBITER_GAP_EN
      pend    <= pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_intf_rr_arbiter.sv
// Scoreboard bench for intf_rr_arbiter (N_REQ=4, HOLD_MAX=8, default build without GAP).
module tb_intf_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       preempt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [7:0]  sb[$];
  logic [7:0]  got, want;

  intf_rr_arbiter #(.N_REQ(4), .HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .preempt(preempt)
  );

  always #5 clk = ~clk;

  // Expected record layout: {busy, preempt, gnt_idx, gnt}
  function automatic logic [7:0] e(input logic [3:0] g, input logic [1:0] i, input logic p);
    return {|g, p, i, g};
  endfunction

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] dn, input logic [7:0] exp_v);
    @(negedge clk);
    rst  = r;
    req  = rq;
    done = dn;
    sb.push_back(exp_v);
    @(posedge clk);
    #1;
    got = {busy, preempt, gnt_idx, gnt};
  endtask

  task automatic apply_reset;
    @(negedge clk);
    rst = 1'b1; req = '0; done = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) cyc(1'b1, 4'b1111, 4'b0000, e(4'b0000, 2'd3, 1'b0));
      else       cyc(1'b0, 4'b1111, 4'b0000, e(4'b0001, 2'd0, 1'b0));
      want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL reset[%0d] got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_rotation;
    logic [3:0] oh, nx;
    apply_reset();
    cyc(1'b0, 4'b1111, 4'b0000, e(4'b0001, 2'd0, 1'b0));
    want = sb.pop_front(); total++;
    if (got !== want) begin
      bad++; $display("FAIL rotation_first got=%b want=%b", got, want);
    end
    for (int k = 0; k < 4; k++) begin
      oh = 4'b0001 << k;
      nx = 4'b0001 << ((k + 1) % 4);
      cyc(1'b0, 4'b1111, 4'b0000, e(oh, 2'(k), 1'b0));
      want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL rotation_hold[%0d] got=%b want=%b", k, got, want);
      end
      cyc(1'b0, 4'b1111, oh, e(nx, 2'((k + 1) % 4), 1'b0));
      want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL rotation_handoff[%0d] got=%b want=%b", k, got, want);
      end
    end
  endtask

  task automatic test_timeout(input logic [3:0] rq, input logic [3:0] g0, input logic [1:0] i0,
                              input logic [3:0] g1, input logic [1:0] i1);
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      if (c < 8)       cyc(1'b0, rq, 4'b0000, e(g0, i0, 1'b0));
      else if (c == 8) cyc(1'b0, rq, 4'b0000, e(g1, i1, 1'b1));
      else             cyc(1'b0, rq, 4'b0000, e(g1, i1, 1'b0));
      want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL timeout_req%b[%0d] got=%b want=%b", rq, c, got, want);
      end
    end
  endtask

  task automatic test_simultaneous;
    apply_reset();
    for (int c = 0; c < 11; c++) begin
      if (c < 8)       cyc(1'b0, 4'b0101, 4'b0000, e(4'b0001, 2'd0, 1'b0));
      else if (c == 8) cyc(1'b0, 4'b0100, 4'b0000, e(4'b0100, 2'd2, 1'b0));
      else if (c == 9) cyc(1'b0, 4'b0101, 4'b1011, e(4'b0100, 2'd2, 1'b0));
      else             cyc(1'b0, 4'b0101, 4'b0001, e(4'b0100, 2'd2, 1'b0));
      want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL simultaneous[%0d] got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_idle_wrap;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0:       cyc(1'b0, 4'b0000, 4'b0000, e(4'b0000, 2'd3, 1'b0));
        1:       cyc(1'b0, 4'b1000, 4'b0000, e(4'b1000, 2'd3, 1'b0));
        2:       cyc(1'b0, 4'b0000, 4'b0000, e(4'b0000, 2'd3, 1'b0));
        default: cyc(1'b0, 4'b1001, 4'b0000, e(4'b0001, 2'd0, 1'b0));
      endcase
      want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL idle_wrap[%0d] got=%b want=%b", c, got, want);
      end
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0, 1:    cyc(1'b0, 4'b0100, 4'b0000, e(4'b0100, 2'd2, 1'b0));
        2:       cyc(1'b1, 4'b1111, 4'b0000, e(4'b0000, 2'd3, 1'b0));
        default: cyc(1'b0, 4'b1111, 4'b0000, e(4'b0001, 2'd0, 1'b0));
      endcase
      want = sb.pop_front(); total++;
      if (got !== want) begin
        bad++; $display("FAIL reset_mid[%0d] got=%b want=%b", c, got, want);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; done = '0;
    test_reset();
    test_rotation();
    test_timeout(4'b0101, 4'b0001, 2'd0, 4'b0100, 2'd2);
    test_timeout(4'b0010, 4'b0010, 2'd1, 4'b0010, 2'd1);
    test_simultaneous();
    test_idle_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intf_rr_arbiter.md
# intf_rr_arbiter

Round-robin arbiter that shares one parameterized interface instance (a single slot of an interface array) among `N_REQ` requesting modules inside a generate scope. It grants exclusive ownership to one requester at a time. The owner keeps the grant until it signals completion, drops its request, or exceeds a hold limit. Each requester's port connection is qualified by the one-hot grant.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..16).
- `HOLD_MAX`, 8, maximum consecutive grant cycles per ownership; 0 disables the limit.

Ports:
- `clk`  input  1  sole clock; all logic rising-edge.
- `rst`  input  1  synchronous, active-high reset.
- `req`  input  N_REQ  per-requester request level.
- `done`  input  N_REQ  per-requester completion pulse; ignored unless the bit belongs to the current owner.
- `gnt`  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- `gnt_idx`  output  $clog2(N_REQ)  index of current owner; holds the last owner when `gnt`==0.
- `busy`  output  1  equals |gnt.
- `preempt`  output  1  one-cycle pulse, asserted in the first cycle after a hold-limit revocation.

## Operation
- All outputs are registered. Reset values: `gnt`=0, `gnt_idx`=N_REQ-1, `busy`=0, `preempt`=0. The internal round-robin pointer and `gnt_idx` reset to N_REQ-1, so requester 0 wins first.
- States:
  - IDLE: no owner.
  - OWN: `gnt` nonzero.
  - GAP: one dead cycle; exists only with the macro.
- IDLE: if `req`≠0, choose the first set bit scanning from `gnt_idx`+1 upward with wrap, and enter OWN. Otherwise stay in IDLE.
- OWN, release conditions, evaluated each edge:
  - (a) `done[gnt_idx]`=1;
  - (b) `req[gnt_idx]`=0;
  - (c) the hold counter equals `HOLD_MAX` (when `HOLD_MAX`>0).
- On release, the next owner is chosen by the same scan from `gnt_idx`+1, using the current `req` with the releasing owner's bit masked when (a) or (b) is the cause.
  - Under (c), the releasing owner's bit is not masked, so a sole requester regains the grant.
  - If no candidate exists, go to IDLE.
  - Otherwise go to OWN with the new owner, or to GAP when the macro is defined.
- Hold counter, width $clog2(HOLD_MAX+1):
  - Set to 1 on the first cycle of each ownership and incremented each cycle while OWN.
  - It never wraps, because release at `HOLD_MAX` resets it.
  - Each ownership therefore lasts at most `HOLD_MAX` cycles.
- `preempt` is set only when (c) is the sole release cause. If (a) or (b) holds in the same cycle, no pulse is produced.
- `done` bits from non-owners are discarded and have no effect on any state.
- `rst` asserted mid-ownership: at that edge all outputs, the counter and the pointer return to reset values, and the grant is lost without a `preempt` pulse.

## Timing
- Request to grant latency: `req` seen high at edge t in IDLE gives `gnt` high after edge t, i.e. 1 cycle.
- Handoff without macro: release at edge t gives the new `gnt` in the cycle after edge t. This is zero dead cycles, and `gnt` never has more than one bit set.
- Handoff with macro: the cycle after edge t has `gnt`=0 (GAP), and the new grant appears after edge t+1.
- `preempt` is coincident with the first cycle of the post-revocation state.

## Configuration
- `INTF_RR_ARBITER_GAP_EN`
  - Defined: a mandatory one-cycle GAP state with `gnt`=0 is inserted between any two ownerships, including a sole requester regaining after timeout. This gives the shared interface a turnaround cycle.
  - Undefined: the GAP state is not built and handoff is back-to-back.

## Test plan
- Reset: hold `rst` for 2 cycles with `req`=4'b1111. Required: `gnt`=0 during reset, then `gnt`=4'b0001 one cycle after `rst` deasserts.
- Rotation: `req`=4'b1111 held, each owner pulses `done` on its 2nd grant cycle. Required: grant order 0,1,2,3,0, with 2-cycle ownerships and no dead cycles (without macro).
- Timeout: `HOLD_MAX`=8, `req`=4'b0101, and owner 0 never pulses `done`. Required: `gnt`=0001 for exactly 8 cycles, then `gnt`=0100 with `preempt`=1 for one cycle.
- Sole-requester timeout: `req`=4'b0010 only. Required: `gnt`=0010 for 8 cycles, `preempt` pulse, `gnt` stays 0010 (or shows 1 cycle of 0 with macro).
- Simultaneous events: owner drops `req` and the counter reaches `HOLD_MAX` in the same cycle. Required: `preempt`=0. A non-owner `done` pulse changes nothing.
- Reset mid-operation: `rst` asserted while `gnt`=0100. Required: next cycle `gnt`=0, `gnt_idx`=3, `preempt`=0, and requester 0 is granted first after release of reset.
